demux_1_4_stream: RTL and testbench
===================================

DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter: WIDTH, default 4, data width of every channel.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 up_valid  input  1  upstream word present.
REQ-005 up_ready  output  1  block accepts the upstream word this cycle.
REQ-006 up_data  input  WIDTH  upstream word.
REQ-007 up_sel  input  2  destination channel index 0..3, qualified by up_valid.
REQ-008 down_valid  output  4  bit i: channel i holds a word.
REQ-009 down_ready  input  4  bit i: channel i consumer accepts.
REQ-010 down_data0, down_data1, down_data2, down_data3  output  WIDTH each  channel i word.

Function
REQ-011 Upstream transfer occurs when up_valid and up_ready are both 1 in the same cycle; channel i transfer when down_valid[i] and down_ready[i] are both 1.
REQ-012 Each channel shall own one one-entry holding slot; down_valid[i] is 1 exactly when slot i is full; down_data<i> shows slot i contents.
REQ-013 An upstream transfer with up_sel = i shall load slot i at the clock edge; the word is visible on down_data<i> with down_valid[i] = 1 the following cycle (latency 1).
REQ-014 up_ready shall be combinational: 1 when slot[up_sel] is empty, or full with down_ready[up_sel] = 1 in the same cycle; independent of the other three channels.
REQ-015 Simultaneous drain and load of the same slot shall leave it full with the new word; no bubble, full throughput of one word per cycle per channel.
REQ-016 Drain of slot j and load of slot i (i /= j) in the same cycle shall both take effect.
REQ-017 A blocked channel shall not block upstream words addressed to other channels in later cycles; no reordering within a channel.
REQ-018 down_data<i> and down_valid[i] shall remain stable while down_valid[i] = 1 and down_ready[i] = 0.
REQ-019 up_ready shall not depend on up_valid; up_data and up_sel are don't-care while up_valid = 0.
REQ-020 Word content shall pass unchanged, bit for bit, WIDTH bits; no arithmetic.

Reset
REQ-021 While rst = 1 at an edge, all four slots shall become empty: down_valid = 4'b0000.
REQ-022 Slot data registers need no reset; down_data<i> is undefined while down_valid[i] = 0.
REQ-023 During rst = 1, up_ready shall be 0 and no transfer shall be recorded, including mid-stream; words held at reset are discarded.
REQ-024 First upstream acceptance possible in the cycle after rst deasserts.

Structure
REQ-025 Shared package demux_pkg: N_CH = 4, SEL_W = 2, and default WIDTH constant.
REQ-026 One sub-module demux_slot (one-entry register slice: valid/ready in, valid/ready out, WIDTH data), instantiated four times.
REQ-027 The top shall contain only the up_sel decode, per-slot load enable and up_ready select.

Verification
REQ-028 Reset: drive rst = 1 with up_valid = 1 for 3 cycles -> up_ready = 0, down_valid = 0000 throughout and one cycle after release.
REQ-029 Routing: send 4'hA sel 0, 4'h5 sel 1, 4'hC sel 2, 4'h3 sel 3 with down_ready = 1111 -> each appears one cycle later on its channel only, one word per cycle.
REQ-030 Backpressure: down_ready[2] = 0, send 4'h1 then 4'h2 to sel 2 -> 4'h1 held stable, up_ready = 0 for the second word until down_ready[2] = 1, then 4'h2 follows with no gap.
REQ-031 Independence: channel 1 full and stalled; send 4'h7 sel 3 -> accepted immediately, down_data3 = 4'h7 next cycle.
REQ-032 Simultaneous: channel 0 full with 4'h9, down_ready[0] = 1 while sending 4'hE sel 0 -> same-edge drain and load; down_data0 = 4'hE, down_valid[0] = 1.
REQ-033 Random: 2000 cycles of random valid/ready/sel with a per-channel FIFO scoreboard -> no loss, duplication or reordering; REQ-018 stability asserted every cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int N_CH          = 4;
  localparam int SEL_W         = 2;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/demux_slot.sv
// One-entry register slice: holds a single word per channel and accepts a new
// word whenever it is empty or being drained in the same cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             full_r;
  logic [WIDTH-1:0] data_r;
  logic             load_s;

  // Ready is forced low during reset so no word is recorded mid-reset.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = ~full_r | out_ready;
    end
    load_s = in_valid & in_ready;
  end

  // Occupancy flag: load wins over drain so simultaneous drain+load stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r <= 1'b0;
    end else if (load_s) begin
      full_r <= 1'b1;
    end else if (out_ready) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  // Data holding register; only meaningful while full_r is set.
  always_ff @(posedge clk) begin
    if (load_s) begin
      data_r <= in_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign out_valid = full_r;
  assign out_data  = data_r;

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demultiplexer: routes each upstream word to the slot chosen by
// up_sel; each channel has its own slot so a stalled channel blocks no other.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [1:0]       up_sel,
  output logic [3:0]       down_valid,
  input  logic [3:0]       down_ready,
  output logic [WIDTH-1:0] down_data0,
  output logic [WIDTH-1:0] down_data1,
  output logic [WIDTH-1:0] down_data2,
  output logic [WIDTH-1:0] down_data3
);

  logic [N_CH-1:0]  load_valid_s;
  logic [N_CH-1:0]  slot_ready_s;
  logic [WIDTH-1:0] slot_data_s [N_CH];

  // One-hot decode of the destination channel.
  always_comb begin
    load_valid_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (up_valid && (up_sel == SEL_W'(i))) begin
        load_valid_s[i] = 1'b1;
      end else begin
        load_valid_s[i] = 1'b0;
      end
    end
  end

  // up_ready follows only the addressed slot, never up_valid.
  always_comb begin
    up_ready = 1'b0;
    case (up_sel)
      2'd0:    up_ready = slot_ready_s[0];
      2'd1:    up_ready = slot_ready_s[1];
      2'd2:    up_ready = slot_ready_s[2];
      2'd3:    up_ready = slot_ready_s[3];
      default: up_ready = 1'b0;
    endcase
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (load_valid_s[g]),
      .in_ready  (slot_ready_s[g]),
      .in_data   (up_data),
      .out_valid (down_valid[g]),
      .out_ready (down_ready[g]),
      .out_data  (slot_data_s[g])
    );
  end

  assign down_data0 = slot_data_s[0];
  assign down_data1 = slot_data_s[1];
  assign down_data2 = slot_data_s[2];
  assign down_data3 = slot_data_s[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed and random self-checking bench for demux_1_4_stream.
module tb_demux_1_4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] up_data;
  logic [1:0] up_sel;
  logic [3:0] down_valid;
  logic [3:0] down_ready;
  logic [3:0] down_data0, down_data1, down_data2, down_data3;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1_4_stream #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_sel     (up_sel),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data0 (down_data0),
    .down_data1 (down_data1),
    .down_data2 (down_data2),
    .down_data3 (down_data3)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] chan_data(int ch);
    case (ch)
      0:       return down_data0;
      1:       return down_data1;
      2:       return down_data2;
      default: return down_data3;
    endcase
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    up_valid   = 1'b0;
    down_ready = 4'b1111;
    step();
    down_ready = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_valid = 1'b1; up_sel = 2'd0; up_data = 4'hF; down_ready = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (up_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_up_ready cycle %0d: got %b want 0", c, up_ready);
      end
      n_checks++;
      if (down_valid !== 4'b0000) begin
        n_fail++; $display("FAIL reset_down_valid cycle %0d: got %b want 0000", c, down_valid);
      end
    end
    step();
    rst = 1'b0; up_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (down_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release_valid: got %b want 0000", down_valid);
    end
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", up_ready);
    end
  endtask

  task automatic test_routing();
    logic [3:0] words [4];
    logic [3:0] onehot;
    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC; words[3] = 4'h3;
    down_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      up_valid = 1'b1; up_sel = 2'(k); up_data = words[k];
      @(negedge clk);
      n_checks++;
      if (up_ready !== 1'b1) begin
        n_fail++; $display("FAIL route_ready ch%0d: got %b want 1", k, up_ready);
      end
      step();
      if (k == 3) up_valid = 1'b0;
      @(negedge clk);
      onehot = 4'b0001 << k;
      n_checks++;
      if (down_valid !== onehot) begin
        n_fail++; $display("FAIL route_valid ch%0d: got %b want %b", k, down_valid, onehot);
      end
      n_checks++;
      if (chan_data(k) !== words[k]) begin
        n_fail++; $display("FAIL route_data ch%0d: got %h want %h", k, chan_data(k), words[k]);
      end
      step();
    end
    drain_all();
  endtask

  task automatic test_backpressure();
    down_ready = 4'b1011;
    up_valid = 1'b1; up_sel = 2'd2; up_data = 4'h1;
    @(negedge clk);
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_ready: got %b want 1", up_ready);
    end
    step();
    up_data = 4'h2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (up_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall_ready cycle %0d: got %b want 0", c, up_ready);
      end
      n_checks++;
      if (down_valid[2] !== 1'b1 || down_data2 !== 4'h1) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: got v=%b d=%h want v=1 d=1", c, down_valid[2], down_data2);
      end
      step();
    end
    down_ready = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1", up_ready);
    end
    step();
    up_valid = 1'b0; down_ready = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (down_valid[2] !== 1'b1 || down_data2 !== 4'h2) begin
      n_fail++; $display("FAIL bp_second_word: got v=%b d=%h want v=1 d=2", down_valid[2], down_data2);
    end
    drain_all();
  endtask

  task automatic test_independence();
    down_ready = 4'b0000;
    up_valid = 1'b1; up_sel = 2'd1; up_data = 4'h4;
    step();
    up_sel = 2'd3; up_data = 4'h7;
    @(negedge clk);
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++; $display("FAIL indep_ready: got %b want 1", up_ready);
    end
    step();
    up_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (down_valid !== 4'b1010) begin
      n_fail++; $display("FAIL indep_valid: got %b want 1010", down_valid);
    end
    n_checks++;
    if (down_data3 !== 4'h7 || down_data1 !== 4'h4) begin
      n_fail++; $display("FAIL indep_data: got d3=%h d1=%h want d3=7 d1=4", down_data3, down_data1);
    end
    drain_all();
  endtask

  task automatic test_simultaneous();
    down_ready = 4'b0000;
    up_valid = 1'b1; up_sel = 2'd0; up_data = 4'h9;
    step();
    down_ready = 4'b0001; up_data = 4'hE;
    @(negedge clk);
    n_checks++;
    if (up_ready !== 1'b1 || down_data0 !== 4'h9) begin
      n_fail++; $display("FAIL simul_pre: got rdy=%b d0=%h want rdy=1 d0=9", up_ready, down_data0);
    end
    step();
    up_valid = 1'b0; down_ready = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (down_valid[0] !== 1'b1 || down_data0 !== 4'hE) begin
      n_fail++; $display("FAIL simul_post: got v=%b d0=%h want v=1 d0=e", down_valid[0], down_data0);
    end
    drain_all();
  endtask

  task automatic test_random();
    logic [3:0] sb [4][$];
    logic       prev_hold [4];
    logic [3:0] prev_data [4];
    logic       exp_ready;
    int         sel_i;
    for (int i = 0; i < 4; i++) prev_hold[i] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      up_valid   = 1'($urandom_range(0, 1));
      up_sel     = 2'($urandom_range(0, 3));
      up_data    = 4'($urandom_range(0, 15));
      down_ready = 4'($urandom_range(0, 15));
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (down_valid[i] !== (sb[i].size() != 0)) begin
          n_fail++; $display("FAIL rand_valid cyc %0d ch%0d: got %b want %b", cyc, i, down_valid[i], sb[i].size() != 0);
        end else if (sb[i].size() != 0 && chan_data(i) !== sb[i][0]) begin
          n_fail++; $display("FAIL rand_data cyc %0d ch%0d: got %h want %h", cyc, i, chan_data(i), sb[i][0]);
        end
        if (prev_hold[i]) begin
          n_checks++;
          if (down_valid[i] !== 1'b1 || chan_data(i) !== prev_data[i]) begin
            n_fail++; $display("FAIL rand_stable cyc %0d ch%0d: got v=%b d=%h want v=1 d=%h", cyc, i, down_valid[i], chan_data(i), prev_data[i]);
          end
        end
      end
      sel_i = int'(up_sel);
      exp_ready = (sb[sel_i].size() == 0) || down_ready[sel_i];
      n_checks++;
      if (up_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_up_ready cyc %0d: got %b want %b", cyc, up_ready, exp_ready);
      end
      for (int i = 0; i < 4; i++) begin
        prev_hold[i] = (sb[i].size() != 0) && !down_ready[i];
        if (prev_hold[i]) prev_data[i] = sb[i][0];
        if (sb[i].size() != 0 && down_ready[i]) void'(sb[i].pop_front());
      end
      if (up_valid && exp_ready) sb[sel_i].push_back(up_data);
      step();
    end
    drain_all();
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_sel = 2'd0; up_data = 4'h0; down_ready = 4'b0000;
    #1;
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
